// File: rtl/buttons_in.sv
// Purpose: synchronise, debounce and edge-latch up to 16 button inputs as a Hack memory-mapped peripheral (LEVEL / EVENT W1C / MASK).
// Latency: raw edge to LEVEL/EVENT is 2 sync cycles plus 3 qualifying debounce ticks; read data is combinational.
// Backpressure: none; the CPU bus always completes, and the prescaler tick is never stalled by bus activity. Optional macro: BUTTONS_IRQ_EN.
module buttons_in #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    input  logic             sel,
    input  logic [1:0]       addr,
    input  logic             load,
    input  logic [15:0]      in,
    output logic [15:0]      out
`ifdef BUTTONS_IRQ_EN
    ,
    output logic             irq
`endif
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_LEVEL = 2'd0;
    localparam logic [1:0] ADDR_EVENT = 2'd1;
    localparam logic [1:0] ADDR_MASK  = 2'd2;

    // Two-flop synchroniser stages
    logic [WIDTH-1:0] syncMeta;
    logic [WIDTH-1:0] sync;

    // Debounce sample history: the current synchronised value is the
    // newest of the three samples, histA and histB are the two before it.
    logic [WIDTH-1:0] histA;
    logic [WIDTH-1:0] histB;

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] evt;

    logic [CNT_W-1:0] preCnt;
    logic             tick;

    logic [WIDTH-1:0] allHigh;
    logic [WIDTH-1:0] allLow;
    logic [WIDTH-1:0] levelNext;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] clrMask;
    logic [WIDTH-1:0] evtNext;
    logic             wrEvt;
    logic [15:0]      rdSel;

`ifdef BUTTONS_IRQ_EN
    logic [WIDTH-1:0] maskReg;
    logic             wrMask;
`endif

    // Bring the asynchronous inputs into the clk domain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            syncMeta <= '0;
            sync     <= '0;
        end else begin
            syncMeta <= raw;
            sync     <= syncMeta;
        end
    end

    // Free-running prescaler; wraps after DEBOUNCE_CYCLES-1 regardless of bus traffic
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            preCnt <= '0;
        end else if (tick) begin
            preCnt <= '0;
        end else begin
            preCnt <= preCnt + CNT_W'(1);
        end
    end

    assign tick = (preCnt == CNT_LAST);

    // Qualify a new level when the three samples agree, and derive events and W1C clears
    always_comb begin
        allHigh   = sync & histA & histB;
        allLow    = ~(sync | histA | histB);
        levelNext = level;
        if (tick) begin
            levelNext = (level & ~allLow) | allHigh;
        end
        rise    = levelNext & ~level;
        wrEvt   = sel && load && (addr == ADDR_EVENT);
        clrMask = '0;
        if (wrEvt) begin
            clrMask = in[WIDTH-1:0];
        end
        // A rising edge in the same cycle as a clear wins
        evtNext = (evt & ~clrMask) | rise;
    end

    // Shift the sample history on each tick and register level/event state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            histA <= '0;
            histB <= '0;
            level <= '0;
            evt   <= '0;
        end else begin
            if (tick) begin
                histA <= sync;
                histB <= histA;
            end
            level <= levelNext;
            evt   <= evtNext;
        end
    end

`ifdef BUTTONS_IRQ_EN
    assign wrMask = sel && load && (addr == ADDR_MASK);

    // Interrupt enable mask register and registered interrupt output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            maskReg <= '0;
            irq     <= 1'b0;
        end else begin
            if (wrMask) begin
                maskReg <= in[WIDTH-1:0];
            end
            irq <= |(evt & maskReg);
        end
    end
`endif

    // Combinational read mux, zero-extended and gated by the select
    always_comb begin
        rdSel = '0;
        case (addr)
            ADDR_LEVEL: rdSel[WIDTH-1:0] = level;
            ADDR_EVENT: rdSel[WIDTH-1:0] = evt;
            ADDR_MASK: begin
`ifdef BUTTONS_IRQ_EN
                rdSel[WIDTH-1:0] = maskReg;
`endif
            end
            default: rdSel = '0;
        endcase
        out = sel ? rdSel : 16'h0000;
    end

endmodule

// File: tb/tb_buttons_in.sv
// Purpose: directed scoreboard bench for buttons_in with DEBOUNCE_CYCLES=4, WIDTH=16.
// Latency: expected values are pushed at issue time and popped by a monitor on the following falling edge.
// Backpressure: none; every issued read/irq check is consumed by the monitor in the same cycle.
module tb_buttons_in;

    typedef struct {
        string       name;
        logic [15:0] val;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [15:0] raw;
    logic        sel;
    logic [1:0]  addr;
    logic        load;
    logic [15:0] busIn;
    logic [15:0] rdDat;
`ifdef BUTTONS_IRQ_EN
    logic        irq;
`endif

    int   checks;
    int   errors;
    int   edgeNo;
    logic rdVld;
    logic irqVld;
    exp_t outQ[$];
    exp_t irqQ[$];

    buttons_in #(
        .WIDTH          (16),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .raw  (raw),
        .sel  (sel),
        .addr (addr),
        .load (load),
        .in   (busIn),
        .out  (rdDat)
`ifdef BUTTONS_IRQ_EN
        ,
        .irq  (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges since reset release; tick edges are multiples of 4
    always @(posedge clk or negedge reset) begin
        if (!reset) edgeNo = 0;
        else        edgeNo = edgeNo + 1;
    end

    // Monitor: pop and compare whenever a check is presented
    always @(negedge clk) begin
        exp_t e;
        if (rdVld) begin
            if (outQ.size() == 0) begin
                errors = errors + 1;
                $display("FAIL outQ underflow at t=%0t", $time);
            end else begin
                e = outQ.pop_front();
                checks = checks + 1;
                if (rdDat !== e.val)
                    begin
                        errors = errors + 1;
                        $display("FAIL %s out=%h expected=%h", e.name, rdDat, e.val);
                    end
            end
        end
`ifdef BUTTONS_IRQ_EN
        if (irqVld) begin
            if (irqQ.size() == 0) begin
                errors = errors + 1;
                $display("FAIL irqQ underflow at t=%0t", $time);
            end else begin
                e = irqQ.pop_front();
                checks = checks + 1;
                if ({15'd0, irq} !== e.val)
                    begin
                        errors = errors + 1;
                        $display("FAIL %s irq=%b expected=%b", e.name, irq, e.val[0]);
                    end
            end
        end
`endif
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
        sel    = 1'b0;
        load   = 1'b0;
        rdVld  = 1'b0;
        irqVld = 1'b0;
    endtask

    task automatic waitEdge(input int n);
        if (edgeNo > n) begin
            errors = errors + 1;
            $display("FAIL sequencing edge=%0d wanted=%0d", edgeNo, n);
        end
        while (edgeNo < n) step();
    endtask

    task automatic rd(input logic [1:0] a, input logic [15:0] v, input string nm);
        exp_t e;
        sel  = 1'b1;
        addr = a;
        e.name = nm;
        e.val  = v;
        outQ.push_back(e);
        rdVld = 1'b1;
    endtask

    task automatic rdNoSel(input logic [1:0] a, input string nm);
        exp_t e;
        sel  = 1'b0;
        addr = a;
        e.name = nm;
        e.val  = 16'h0000;
        outQ.push_back(e);
        rdVld = 1'b1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        sel   = 1'b1;
        load  = 1'b1;
        addr  = a;
        busIn = d;
    endtask

    task automatic chkIrq(input logic v, input string nm);
        exp_t e;
        e.name = nm;
        e.val  = {15'd0, v};
        irqQ.push_back(e);
        irqVld = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        raw    = 16'hFFFF;
        sel    = 1'b0;
        addr   = 2'd0;
        load   = 1'b0;
        busIn  = 16'h0000;
        rdVld  = 1'b0;
        irqVld = 1'b0;

        // Phase 1: all inputs high through reset, then qualify
        step();
        step();
        rd(2'd0, 16'h0000, "rstLevel");
`ifdef BUTTONS_IRQ_EN
        chkIrq(1'b0, "rstIrq");
`endif
        step();
        rd(2'd1, 16'h0000, "rstEvent");
        step();
        reset = 1'b1;
        waitEdge(1);
        rd(2'd0, 16'h0000, "lvlEarly");
        step();
        rd(2'd1, 16'h0000, "evtEarly");
        step();
        waitEdge(11);
        rd(2'd0, 16'h0000, "lvlPreQual");
        step();
        rd(2'd0, 16'hFFFF, "lvlQual");
        step();
        rd(2'd1, 16'hFFFF, "evtQual");
        step();

        // Asynchronous reset mid-cycle clears state immediately
        #2;
        reset = 1'b0;
        raw   = 16'h0000;
        rd(2'd1, 16'h0000, "asyncRstEvt");
        step();
        step();
        reset = 1'b1;

        // Phase 2: glitch on bit 3 (6 cycles) is rejected
        raw[3] = 1'b1;
        waitEdge(6);
        raw[3] = 1'b0;
        waitEdge(13);
        rd(2'd0, 16'h0000, "glitchLvl");
        step();
        rd(2'd1, 16'h0000, "glitchEvt");
        step();
        waitEdge(16);
        raw[3] = 1'b1;
        waitEdge(27);
        rd(2'd0, 16'h0000, "holdLvlPre");
        step();
        rd(2'd0, 16'h0008, "holdLvl");
        step();
        rd(2'd1, 16'h0008, "holdEvt");
        step();
        waitEdge(30);
        raw[0] = 1'b1;
        waitEdge(43);
        rd(2'd1, 16'h0008, "evtPreBit0");
        step();
        rd(2'd1, 16'h0009, "evtBit0");
        step();
        rd(2'd0, 16'h0009, "lvlBit0");
        step();
        // W1C bit 0, visible the next cycle
        wr(2'd1, 16'h0001);
        step();
        rd(2'd1, 16'h0008, "w1cBit0");
        // LEVEL is read-only
        step();
        wr(2'd0, 16'hFFFF);
        step();
        rd(2'd0, 16'h0009, "levelRO");
        step();
        rd(2'd3, 16'h0000, "addr3Zero");
        step();
        rd(2'd2, 16'h0000, "addr2Zero");
        step();
        raw[5] = 1'b1;
        // Clear bits 3 and 5 on the edge bit 5 qualifies: set wins on 5
        waitEdge(63);
        wr(2'd1, 16'h0028);
        step();
        rd(2'd1, 16'h0020, "setBeatsClr");
        step();
        rd(2'd0, 16'h0029, "lvlBit5");
        step();
        // Release bit 3: LEVEL falls, EVENT not set
        raw[3] = 1'b0;
        waitEdge(79);
        rd(2'd0, 16'h0029, "relLvlPre");
        step();
        rd(2'd0, 16'h0021, "relLvl");
        step();
        rd(2'd1, 16'h0020, "relNoEvt");
        step();
        raw[1] = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rdNoSel(2'(a), "noSel");
            step();
        end

        // Phase 3: reset while bit 1 is mid-debounce; held inputs re-qualify
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        waitEdge(11);
        rd(2'd1, 16'h0000, "reqEvtPre");
        step();
        rd(2'd1, 16'h0023, "reqEvt");
        step();
        rd(2'd0, 16'h0023, "reqLvl");
        step();

`ifdef BUTTONS_IRQ_EN
        // Phase 4: interrupt masking
        raw   = 16'h0000;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        wr(2'd2, 16'h0008);
        step();
        rd(2'd2, 16'h0008, "maskRd");
        step();
        raw[2] = 1'b1;
        waitEdge(16);
        rd(2'd1, 16'h0004, "evtBit2");
        chkIrq(1'b0, "irqBit2a");
        step();
        chkIrq(1'b0, "irqBit2b");
        step();
        raw[3] = 1'b1;
        waitEdge(32);
        rd(2'd1, 16'h000C, "evtBit3");
        chkIrq(1'b0, "irqPre");
        step();
        chkIrq(1'b1, "irqRise");
        step();
        wr(2'd1, 16'h0008);
        chkIrq(1'b1, "irqHold");
        step();
        chkIrq(1'b1, "irqW1cEdge");
        step();
        chkIrq(1'b0, "irqDrop");
        wr(2'd2, 16'h0004);
        step();
        chkIrq(1'b0, "irqMaskEdge");
        step();
        chkIrq(1'b1, "irqMaskBit2");
        step();
`endif

        step();
        step();
        checks = checks + 1;
        if (outQ.size() != 0 || irqQ.size() != 0) begin
            errors = errors + 1;
            $display("FAIL queueDrain outQ=%0d irqQ=%0d required=0", outQ.size(), irqQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/buttons_in.md
# buttons_in

Memory-mapped input peripheral for the Hack computer. It carries data from the outside world to the CPU, the opposite direction to the LED output peripheral. It synchronizes and debounces up to 16 raw button/switch inputs and latches rising-edge events for the CPU to poll. It sits on the CPU data bus beside RAM and LEDs, selected by its own AddressDecoder `slaveSel` bit, and its `out` feeds the memory output mux.

## Interface
- `WIDTH`, 16: number of input bits, 1..16; unused upper `out` bits read 0.
- `DEBOUNCE_CYCLES`, 50000: `clk` cycles between debounce sample ticks, ≥2.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `raw`  in  WIDTH  asynchronous button/switch inputs, active-high.
- `sel`  in  1  peripheral selected by address decoder.
- `addr`  in  2  register select (`memAddress[1:0]`).
- `load`  in  1  CPU write strobe (`writeM`), qualified by `sel`.
- `in`  in  16  CPU write data (`outM`).
- `out`  out  16  read data, combinational from registers.
- `irq`  out  1  event interrupt, present only with `BUTTONS_IRQ_EN`.

## Operation
- Synchronizer: two flops per bit, `raw` → `sync`.
- Prescaler: counter runs 0..`DEBOUNCE_CYCLES`-1 and wraps; `tick` is high for one cycle when the counter equals `DEBOUNCE_CYCLES`-1.
- Debounce: on each `tick`, shift `sync[i]` into a per-bit 3-deep sample history.
  - When all 3 samples equal and differ from `level[i]`, `level[i]` takes that value.
  - Otherwise `level[i]` holds, so glitches shorter than 3 ticks are rejected.
- Event: `event[i]` sets on the edge where `level[i]` goes 0→1. A 1→0 change sets nothing.
- Register map, by `addr`:
  - 0, LEVEL (RO): `level`. Writes ignored.
  - 1, EVENT (W1C): `event`. A write with `sel&load` clears every bit where `in[i]`=1.
  - 2, MASK (RW): see Configuration.
  - 3: reads 0; writes ignored.
- Set beats clear: if a rising edge and a W1C on the same bit coincide, the bit ends at 1.
- `out` = selected register zero-extended to 16 bits, gated by `sel` (0 when `sel`=0).
- Reads have no side effects. The CPU may sample `inM` repeatedly within an instruction.

## Timing
- Reset (asserted `reset`=0), applied asynchronously:
  - `sync`, sample history, `level`, `event`, `mask` and the prescaler all go to 0.
  - `out` = 0 and `irq` = 0.
- After reset release, the prescaler starts at 0, so the first `tick` comes `DEBOUNCE_CYCLES` cycles later.
- Latency, `raw` edge to `level` update: 2 cycles of sync, then the 3rd qualifying `tick` edge. Worst case is 2 + 3·`DEBOUNCE_CYCLES` cycles.
- `event` updates on the same clock edge as `level`.
- `out` is combinational: it reflects register state in the same cycle as `sel`/`addr`.
- A W1C takes effect on the clock edge at which `sel&load` is high, so a read on the next cycle shows the cleared value.
- Reset mid-debounce discards the history. A held input re-qualifies from scratch after reset and then sets `event`.
- Prescaler wrap is continuous. `tick` is never suppressed by bus activity.

## Configuration
- Macro `BUTTONS_IRQ_EN`.
- Defined:
  - Adds the `irq` port and the MASK register at `addr` 2. MASK is RW, reset 0, low WIDTH bits.
  - `irq` = registered `|(event & mask)`, valid one cycle after the causing `event`/`mask` change.
  - `irq` drops one cycle after the W1C that clears the last enabled event.
- Undefined:
  - No `irq` port and no MASK flops.
  - `addr` 2 reads 0 and ignores writes.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4 and `WIDTH`=16.
- Reset: hold `reset`=0 with `raw`=16'hFFFF, then release → LEVEL and EVENT read 0 until debounce completes; after 2+12 cycles LEVEL = 16'hFFFF and EVENT = 16'hFFFF.
- Glitch rejection: pulse `raw[3]` high for 6 cycles → LEVEL and EVENT bit 3 stay 0. Then hold `raw[3]` high for ≥14 cycles → LEVEL = 16'h0008 and EVENT = 16'h0008.
- W1C: with EVENT = 16'h0009, write `in`=16'h0001 to `addr` 1 → EVENT reads 16'h0008 next cycle. Writing 16'hFFFF to `addr` 0 leaves LEVEL unchanged.
- Simultaneous set/clear: arrange a `raw[5]` rising qualification on the same edge as a W1C of bit 5 → EVENT[5] = 1.
- Release: drop `raw[3]` → LEVEL[3] goes 0 after debounce and EVENT[3] is not set. With `sel`=0, `out` = 16'h0000 for any `addr`.
- `BUTTONS_IRQ_EN`:
  - Write MASK = 16'h0008 and trigger bit 3 → `irq`=1 one cycle after EVENT[3] sets.
  - W1C bit 3 → `irq`=0 on the next cycle.
  - An event on bit 2 alone never raises `irq`.
